ux607_i2c_master_byte_ctrl: RTL and testbench
=============================================

Name: ux607_i2c_master_byte_ctrl

Overview:
Byte-level sequencer for the I2C master. It sits directly upstream of ux607_i2c_master_bit_ctrl and sits between that block and the register/control block. It turns one register-level request (start/stop/read/write plus byte data) into the ordered sequence of bit-controller commands: START, 8 data bits, ACK bit, optional STOP. It returns the received byte, the received ACK bit and a one-cycle completion pulse.

Parameters:
None. Byte width is fixed at 8 and the bit-command encoding is fixed by the shared defines.

Ports:
clk  in  1  system clock; all logic on posedge clk.
nReset  in  1  asynchronous active-low reset.
start  in  1  generate START before the byte.
stop  in  1  generate STOP after the byte (or STOP alone).
read  in  1  read a byte.
write  in  1  write a byte.
ack_in  in  1  ACK bit the master drives after a read (0 = ACK, 1 = NACK).
din  in  8  byte to transmit.
cmd_ack  out  1  one-cycle pulse when the whole request completes.
ack_out  out  1  ACK bit sampled from the slave after a write/read.
dout  out  8  received byte (the shift register).
i2c_busy  out  1  = bit_busy; combinational pass-through.
i2c_al  out  1  = bit_al; combinational pass-through.
core_cmd  out  4  command to the bit controller (NOP/START/STOP/WRITE/READ).
core_txd  out  1  data bit to the bit controller (its din).
core_ack  in  1  bit-controller command done (its cmd_ack).
core_rxd  in  1  bit received from the bit controller (its dout).
bit_busy  in  1  bus busy from the bit controller.
bit_al  in  1  arbitration lost from the bit controller.

Behaviour:
- Reset values (nReset low):
  - state = ST_IDLE, core_cmd = NOP, core_txd = 0.
  - cmd_ack = 0, ack_out = 0, dout = 0, bit counter = 0.
- States: ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP. Use one-hot or binary encoding; it is not externally visible.
- go = (read | write | stop) & ~cmd_ack. The ~cmd_ack term prevents re-launch in the completion cycle while the upstream block clears its request bits.
- "load" means: shift register <= din, bit counter <= 7.
- "shift" means: shift register <= {sr[6:0], core_rxd}, counter <= counter - 1.
- cnt_done = (counter == 0).
- ST_IDLE, on go (priority start > read > write > stop):
  - start: core_cmd = START, go to ST_START.
  - read: core_cmd = READ, go to ST_READ.
  - write: core_cmd = WRITE, go to ST_WRITE.
  - otherwise: core_cmd = STOP, go to ST_STOP.
  - Load in every case.
- ST_START, on core_ack: core_cmd = READ if read, else WRITE; go to ST_READ or ST_WRITE; load.
- ST_WRITE:
  - core_txd = sr[7], MSB first.
  - On core_ack: shift.
  - If cnt_done, go to ST_ACK with core_cmd = READ. Otherwise stay with core_cmd = WRITE.
- ST_READ:
  - On core_ack: shift.
  - If cnt_done, go to ST_ACK with core_cmd = WRITE and core_txd = ack_in. Otherwise stay with core_cmd = READ.
- ST_ACK, on core_ack:
  - ack_out <= core_rxd; core_txd <= 1.
  - If stop: core_cmd = STOP, go to ST_STOP.
  - Else: core_cmd = NOP, cmd_ack = 1, go to ST_IDLE.
- ST_STOP, on core_ack: core_cmd = NOP, cmd_ack = 1, go to ST_IDLE.
- core_cmd is held stable until core_ack. Between commands it never returns to NOP.
- cmd_ack is high for exactly one clk per request. Its default every cycle is 0.
- Counter is 3-bit and counts down without wrap beyond 0; it is reloaded only by load.
- Arbitration lost: bit_al = 1 in any state forces, next edge:
  - state = ST_IDLE, core_cmd = NOP, core_txd = 0, cmd_ack = 0.
  - dout and ack_out hold their values.
- Reset mid-operation aborts immediately to the reset values.
- core_ack in ST_IDLE is ignored.

Decomposition:
- I2C_CMD_NOP = 4'b0000, START = 4'b0001, STOP = 4'b0010, WRITE = 4'b0100, READ = 4'b1000 live in the shared ux607_i2c_master_defines.v. The same encoding is used by the bit controller.
- Byte-controller state encodings are local parameters.
- No sub-module: ux607_i2c_master_bit_ctrl is instantiated beside this block at the I2C top, not inside it. This keeps the byte FSM verifiable against a simple bit-controller model.

Test Plan:
1. start = 1, write = 1, din = 8'hA5; model acks each command after 4 clks and returns core_rxd = 0 in the ACK slot -> core_cmd sequence START, WRITE×8 (core_txd 1,0,1,0,0,1,0,1), READ; then ack_out = 0 and a single cmd_ack pulse; i2c_busy and i2c_al follow their inputs.
2. read = 1, ack_in = 1; model returns bits 0,0,1,1,1,1,0,0 -> READ×8, then WRITE with core_txd = 1; dout = 8'h3C; cmd_ack pulses once.
3. write = 1, stop = 1, din = 8'h00, model ACK bit = 1 -> WRITE×8, READ, STOP; ack_out = 1; cmd_ack only after the STOP core_ack.
4. stop only -> core_cmd = STOP, then cmd_ack one cycle after core_ack. Holding stop high during the cmd_ack cycle does not relaunch.
5. bit_al = 1 after the 3rd WRITE ack -> next clk core_cmd = NOP, state idle, no cmd_ack, i2c_al = 1; a fresh write request then starts cleanly from load.
6. nReset asserted mid-read after 5 bits -> all outputs at their reset values asynchronously; after release the FSM idles until a new go.

Source files
------------

// File: rtl/ux607_i2c_master_byte_ctrl_pkg.sv
// ux607_i2c_master_byte_ctrl_pkg
// Shared definitions for the I2C master byte controller.
//   - Bit-controller command encoding. It must match the encoding the bit
//     controller decodes, so treat these values as fixed.
//   - Byte-controller FSM state type. It is internal to the byte controller.
package ux607_i2c_master_byte_ctrl_pkg;

  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } byte_state_e;

endpackage

// File: rtl/ux607_i2c_master_byte_ctrl.sv
// ux607_i2c_master_byte_ctrl
// Byte-level sequencer for the I2C master. It turns one register-level request
// into an ordered series of bit-controller commands:
//   optional START, 8 data bits, ACK bit, optional STOP.
//
// Ports
//   clk, nReset        : clock; asynchronous active-low reset
//   start/stop/read/write, ack_in, din : request from the register block
//   cmd_ack            : one-cycle pulse when the request completes
//   ack_out            : ACK bit sampled in the ACK slot
//   dout               : shift register (the received byte)
//   i2c_busy, i2c_al   : pass-through of bit_busy and bit_al
//   core_cmd, core_txd : command and data bit sent to the bit controller
//   core_ack, core_rxd : command-done pulse and received bit from the bit controller
//   bit_busy, bit_al   : bus-busy and arbitration-lost flags from the bit controller
module ux607_i2c_master_byte_ctrl
  import ux607_i2c_master_byte_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       nReset,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       i2c_busy,
  output logic       i2c_al,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd,
  input  logic       bit_busy,
  input  logic       bit_al
);

  byte_state_e state, state_next;
  logic [3:0]  cmd_next;
  logic        txd_next;
  logic        cmd_ack_next;
  logic        ack_out_next;
  logic [7:0]  sr, sr_next;
  logic [2:0]  cnt, cnt_next;
  logic        go;
  logic        cnt_done;

  // The ~cmd_ack term stops a relaunch in the completion cycle, while the
  // register block is still clearing its request bits.
  assign go       = (read | write | stop) & ~cmd_ack;
  assign cnt_done = (cnt == 3'd0);

  assign dout     = sr;
  assign i2c_busy = bit_busy;
  assign i2c_al   = bit_al;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= ST_IDLE;
      core_cmd <= I2C_CMD_NOP;
      core_txd <= 1'b0;
      cmd_ack  <= 1'b0;
      ack_out  <= 1'b0;
      sr       <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_next;
      core_cmd <= cmd_next;
      core_txd <= txd_next;
      cmd_ack  <= cmd_ack_next;
      ack_out  <= ack_out_next;
      sr       <= sr_next;
      cnt      <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cmd_next     = core_cmd;
    txd_next     = core_txd;
    cmd_ack_next = 1'b0;
    ack_out_next = ack_out;
    sr_next      = sr;
    cnt_next     = cnt;

    case (state)
      ST_IDLE: begin
        if (go) begin
          sr_next  = din;
          cnt_next = 3'd7;
          if (start) begin
            cmd_next   = I2C_CMD_START;
            state_next = ST_START;
          end else if (read) begin
            cmd_next   = I2C_CMD_READ;
            state_next = ST_READ;
          end else if (write) begin
            cmd_next   = I2C_CMD_WRITE;
            state_next = ST_WRITE;
          end else begin
            cmd_next   = I2C_CMD_STOP;
            state_next = ST_STOP;
          end
        end
      end

      ST_START: begin
        if (core_ack) begin
          sr_next  = din;
          cnt_next = 3'd7;
          if (read) begin
            cmd_next   = I2C_CMD_READ;
            state_next = ST_READ;
          end else begin
            cmd_next   = I2C_CMD_WRITE;
            state_next = ST_WRITE;
          end
        end
      end

      ST_WRITE, ST_READ: begin
        if (core_ack) begin
          sr_next  = {sr[6:0], core_rxd};
          // The counter stops at zero; only a load moves it off zero.
          cnt_next = cnt_done ? cnt : cnt - 3'd1;
          if (cnt_done) begin
            state_next = ST_ACK;
            if (state == ST_WRITE) begin
              // The slave drives the ACK, so the master reads it.
              cmd_next = I2C_CMD_READ;
            end else begin
              // The master drives ACK/NACK after a read.
              cmd_next = I2C_CMD_WRITE;
              txd_next = ack_in;
            end
          end
        end
      end

      ST_ACK: begin
        if (core_ack) begin
          ack_out_next = core_rxd;
          txd_next     = 1'b1;
          if (stop) begin
            cmd_next   = I2C_CMD_STOP;
            state_next = ST_STOP;
          end else begin
            cmd_next     = I2C_CMD_NOP;
            cmd_ack_next = 1'b1;
            state_next   = ST_IDLE;
          end
        end
      end

      ST_STOP: begin
        if (core_ack) begin
          cmd_next     = I2C_CMD_NOP;
          cmd_ack_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cmd_next   = I2C_CMD_NOP;
      end
    endcase

    // While a data bit is being written, core_txd tracks the MSB of the
    // shift register. The data bit is therefore valid on the same edge
    // that issues or continues the WRITE command.
    if (state_next == ST_WRITE) begin
      txd_next = sr_next[7];
    end

    // Arbitration lost aborts the transfer. The received byte and the
    // ACK bit are kept for software to inspect.
    if (bit_al) begin
      state_next   = ST_IDLE;
      cmd_next     = I2C_CMD_NOP;
      txd_next     = 1'b0;
      cmd_ack_next = 1'b0;
      ack_out_next = ack_out;
      sr_next      = sr;
      cnt_next     = cnt;
    end
  end

endmodule

// File: tb/tb_ux607_i2c_master_byte_ctrl.sv
// Self-checking bench for ux607_i2c_master_byte_ctrl.
// A small bit-controller model acks every non-NOP command after 4 clocks.
// On READ it returns queued bits. On WRITE it echoes core_txd.
// The expected command/txd sequence is pushed to a scoreboard when a request
// is driven, and popped on each core_ack.
module tb_ux607_i2c_master_byte_ctrl;
  import ux607_i2c_master_byte_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       nReset;
  logic       start, stop, read, write, ack_in;
  logic [7:0] din;
  logic       cmd_ack, ack_out, i2c_busy, i2c_al;
  logic [7:0] dout;
  logic [3:0] core_cmd;
  logic       core_txd;
  logic       core_ack, core_rxd;
  logic       bit_busy, bit_al;

  always #5 clk = ~clk;

  ux607_i2c_master_byte_ctrl dut (
    .clk(clk), .nReset(nReset), .start(start), .stop(stop), .read(read),
    .write(write), .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack),
    .ack_out(ack_out), .dout(dout), .i2c_busy(i2c_busy), .i2c_al(i2c_al),
    .core_cmd(core_cmd), .core_txd(core_txd), .core_ack(core_ack),
    .core_rxd(core_rxd), .bit_busy(bit_busy), .bit_al(bit_al)
  );

  typedef struct packed {
    logic [3:0] cmd;
    logic       chk_txd;
    logic       txd;
  } exp_t;

  exp_t exp_q[$];
  logic rx_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ack_pulses = 0;
  int   mdl_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Bit-controller model.
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      core_ack <= 1'b0;
      core_rxd <= 1'b1;
      mdl_wait <= 0;
    end else begin
      core_ack <= 1'b0;
      if (core_cmd != I2C_CMD_NOP && !core_ack) begin
        if (mdl_wait == 3) begin
          mdl_wait <= 0;
          core_ack <= 1'b1;
          if (core_cmd == I2C_CMD_READ) begin
            if (rx_q.size() != 0) core_rxd <= rx_q.pop_front();
            else                  core_rxd <= 1'b1;
          end else if (core_cmd == I2C_CMD_WRITE) begin
            core_rxd <= core_txd;
          end else begin
            core_rxd <= 1'b1;
          end
        end else begin
          mdl_wait <= mdl_wait + 1;
        end
      end else begin
        mdl_wait <= 0;
      end
    end
  end

  always @(posedge clk) if (nReset && cmd_ack) ack_pulses <= ack_pulses + 1;

  // Scoreboard: compare each acknowledged command against the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (nReset && core_ack) begin
      if (exp_q.size() == 0) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL extra_cmd: observed cmd %0h expected none", core_cmd);
        end
      end else begin
        e = exp_q.pop_front();
        check("core_cmd", 32'(core_cmd), 32'(e.cmd));
        if (e.chk_txd) check("core_txd", 32'(core_txd), 32'(e.txd));
      end
    end
    if (nReset && cmd_ack) check("cmd_ack_before_last_cmd", 32'(exp_q.size()), 32'd0);
  end

  task automatic push_cmd(input logic [3:0] c, input logic chk, input logic t);
    exp_t e;
    e.cmd = c; e.chk_txd = chk; e.txd = t;
    exp_q.push_back(e);
  endtask

  task automatic push_write_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) push_cmd(I2C_CMD_WRITE, 1'b1, b[i]);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (cmd_ack !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cmd_ack), 32'd1);
  endtask

  task automatic wait_sb_empty(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    nReset = 1'b0; start = 0; stop = 0; read = 0; write = 0; ack_in = 0;
    din = 8'h00; bit_busy = 0; bit_al = 0;
    repeat (3) @(negedge clk);
    check("rst_core_cmd", 32'(core_cmd), 32'(I2C_CMD_NOP));
    check("rst_core_txd", 32'(core_txd), 32'd0);
    check("rst_cmd_ack", 32'(cmd_ack), 32'd0);
    check("rst_ack_out", 32'(ack_out), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    nReset = 1'b1;
    @(negedge clk);

    // Combinational pass-through of the bit-controller flags.
    bit_busy = 1; #1;
    check("i2c_busy_hi", 32'(i2c_busy), 32'd1);
    bit_al = 1; #1;
    check("i2c_al_hi", 32'(i2c_al), 32'd1);
    bit_busy = 0; bit_al = 0; #1;
    check("i2c_busy_lo", 32'(i2c_busy), 32'd0);
    check("i2c_al_lo", 32'(i2c_al), 32'd0);
    @(negedge clk);

    // 1: START + write 0xA5, slave ACKs.
    push_cmd(I2C_CMD_START, 0, 0);
    push_write_byte(8'hA5);
    push_cmd(I2C_CMD_READ, 0, 0);
    rx_q.push_back(1'b0);
    p0 = ack_pulses; bit_busy = 1;
    start = 1; write = 1; din = 8'hA5;
    wait_done("t1_timeout");
    start = 0; write = 0;
    @(negedge clk);
    check("t1_cmd_ack_width", 32'(cmd_ack), 32'd0);
    check("t1_idle_nop", 32'(core_cmd), 32'(I2C_CMD_NOP));
    check("t1_ack_out", 32'(ack_out), 32'd0);
    check("t1_dout", 32'(dout), 32'hA5);
    check("t1_pulses", 32'(ack_pulses - p0), 32'd1);
    check("t1_busy", 32'(i2c_busy), 32'd1);
    bit_busy = 0;

    // 2: read with NACK, bits 0,0,1,1,1,1,0,0.
    for (int i = 0; i < 8; i++) push_cmd(I2C_CMD_READ, 0, 0);
    push_cmd(I2C_CMD_WRITE, 1, 1);
    rx_q.push_back(0); rx_q.push_back(0); rx_q.push_back(1); rx_q.push_back(1);
    rx_q.push_back(1); rx_q.push_back(1); rx_q.push_back(0); rx_q.push_back(0);
    p0 = ack_pulses;
    read = 1; ack_in = 1;
    wait_done("t2_timeout");
    read = 0; ack_in = 0;
    @(negedge clk);
    check("t2_dout", 32'(dout), 32'h3C);
    check("t2_ack_out", 32'(ack_out), 32'd1);
    check("t2_pulses", 32'(ack_pulses - p0), 32'd1);

    // 3: write 0x00 + STOP, slave NACKs.
    push_write_byte(8'h00);
    push_cmd(I2C_CMD_READ, 0, 0);
    push_cmd(I2C_CMD_STOP, 0, 0);
    rx_q.push_back(1'b1);
    p0 = ack_pulses;
    write = 1; stop = 1; din = 8'h00;
    wait_done("t3_timeout");
    write = 0; stop = 0;
    @(negedge clk);
    check("t3_ack_out", 32'(ack_out), 32'd1);
    check("t3_dout", 32'(dout), 32'h00);
    check("t3_pulses", 32'(ack_pulses - p0), 32'd1);

    // 4: STOP alone; stop stays high through the completion cycle.
    push_cmd(I2C_CMD_STOP, 0, 0);
    p0 = ack_pulses;
    stop = 1;
    wait_done("t4_timeout");
    @(negedge clk);
    check("t4_no_relaunch", 32'(core_cmd), 32'(I2C_CMD_NOP));
    check("t4_cmd_ack_width", 32'(cmd_ack), 32'd0);
    stop = 0;
    @(negedge clk);
    check("t4_still_nop", 32'(core_cmd), 32'(I2C_CMD_NOP));
    check("t4_pulses", 32'(ack_pulses - p0), 32'd1);

    // 5: arbitration lost after the 3rd WRITE ack, then a clean fresh write.
    push_cmd(I2C_CMD_WRITE, 1, 1); push_cmd(I2C_CMD_WRITE, 1, 0); push_cmd(I2C_CMD_WRITE, 1, 0);
    p0 = ack_pulses;
    write = 1; din = 8'h96;
    wait_sb_empty("t5_three_bits");
    bit_al = 1; write = 0;
    @(negedge clk);
    check("t5_al_nop", 32'(core_cmd), 32'(I2C_CMD_NOP));
    check("t5_al_txd", 32'(core_txd), 32'd0);
    check("t5_al_flag", 32'(i2c_al), 32'd1);
    check("t5_al_dout_hold", 32'(dout), 32'hB4);
    check("t5_al_ack_out_hold", 32'(ack_out), 32'd1);
    bit_al = 0;
    repeat (3) @(negedge clk);
    check("t5_idle_nop", 32'(core_cmd), 32'(I2C_CMD_NOP));
    check("t5_no_cmd_ack", 32'(ack_pulses - p0), 32'd0);
    push_write_byte(8'h5A);
    push_cmd(I2C_CMD_READ, 0, 0);
    rx_q.push_back(1'b0);
    p0 = ack_pulses;
    write = 1; din = 8'h5A;
    wait_done("t5_fresh_timeout");
    write = 0;
    @(negedge clk);
    check("t5_fresh_dout", 32'(dout), 32'h5A);
    check("t5_fresh_ack_out", 32'(ack_out), 32'd0);
    check("t5_fresh_pulses", 32'(ack_pulses - p0), 32'd1);

    // 6: reset in the middle of a read, after 5 bits.
    for (int i = 0; i < 5; i++) push_cmd(I2C_CMD_READ, 0, 0);
    for (int i = 0; i < 8; i++) rx_q.push_back(1'b1);
    read = 1; din = 8'hFF;
    wait_sb_empty("t6_five_bits");
    nReset = 0; read = 0; #1;
    check("t6_rst_cmd", 32'(core_cmd), 32'(I2C_CMD_NOP));
    check("t6_rst_txd", 32'(core_txd), 32'd0);
    check("t6_rst_cmd_ack", 32'(cmd_ack), 32'd0);
    check("t6_rst_ack_out", 32'(ack_out), 32'd0);
    check("t6_rst_dout", 32'(dout), 32'd0);
    rx_q.delete(); exp_q.delete();
    @(negedge clk);
    nReset = 1;
    repeat (5) @(negedge clk);
    check("t6_idle_after_rst", 32'(core_cmd), 32'(I2C_CMD_NOP));
    check("t6_dout_after_rst", 32'(dout), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
